// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS generator/checker pair:
//   - prbs_state_t : checker state (SEED while learning the register, CHECK
//                    while predicting and comparing)
//   - PRBS7_WIDTH / PRBS7_TAPS : default x^7+x^6+1 polynomial
//   - prbsFeedback : XOR-reduced tap feedback, identical on both link ends
// -----------------------------------------------------------------------------
package prbs_pkg;

   typedef enum logic [0:0] {
      SEED,
      CHECK
   } prbs_state_t;

   localparam int unsigned PRBS7_WIDTH = 7;
   localparam logic [6:0]  PRBS7_TAPS  = 7'b1100000;

   // Feedback bit of a Fibonacci LFSR. Narrower registers are zero-extended
   // by the caller so one function serves every legal width (3..32).
   function automatic logic prbsFeedback(input logic [31:0] sr, input logic [31:0] taps);
      return ^(sr & taps);
   endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// -----------------------------------------------------------------------------
// prbs_sat_counter
// CNT_W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous reset, active-low
//   inc_i   : add one this cycle (ignored once saturated)
//   clr_i   : synchronous clear, takes priority over inc_i
//   count_o : current count
// -----------------------------------------------------------------------------
module prbs_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear beats increment so a clear issued on the same cycle as an event
   // always leaves the counter at zero; the all-ones test stops the wrap.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Plain count register with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Receive side of the PRBS link. Learns the remote LFSR state from the first
// WIDTH valid bits, then predicts each following bit, pulses err on every
// mismatch, counts mismatches (saturating) and drops lock when ERR_THRESH
// errors land inside one WINDOW of valid bits.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous reset, active-low
//   d         : serial data bit under test
//   d_valid   : d is sampled on this edge when high
//   clr       : synchronous clear of err_count (and bit_count); lock unaffected
//   locked    : high while in CHECK
//   err       : registered one-cycle pulse per mismatching bit in CHECK
//   err_count : saturating mismatch count since reset/clr
//   bit_count : (PRBS_CHECKER_BITCNT_EN only) saturating count of valid bits
//               accepted in CHECK, the bit-error-rate denominator
// Build option: define PRBS_CHECKER_BITCNT_EN to add bit_count.
// -----------------------------------------------------------------------------
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int unsigned      WIDTH      = PRBS7_WIDTH,
   parameter logic [WIDTH-1:0] TAPS       = PRBS7_TAPS,
   parameter int unsigned      WINDOW     = 64,
   parameter int unsigned      ERR_THRESH = 4,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d,
   input  logic             d_valid,
   input  logic             clr,
   output logic             locked,
   output logic             err,
`ifdef PRBS_CHECKER_BITCNT_EN
   output logic [CNT_W-1:0] bit_count,
`endif
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned SEED_W = $clog2(WIDTH + 1);
   localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
   localparam int unsigned ERR_W  = $clog2(ERR_THRESH + 1);

   prbs_state_t      state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [SEED_W-1:0] seedCnt_q, seedCnt_d;
   logic [WIN_W-1:0] winCnt_q, winCnt_d;
   logic [ERR_W-1:0] winErr_q, winErr_d;
   logic             err_q, err_d;

   logic             predBit;
   logic             checkBit;
   logic             mismatch;
   logic [WIDTH-1:0] srSeed;

   assign predBit  = prbsFeedback(32'(sr_q), 32'(TAPS));
   assign checkBit = d_valid && (state_q == CHECK);
   assign mismatch = checkBit && (d != predBit);
   assign srSeed   = {sr_q[WIDTH-2:0], d};

   // State register: every piece of checker state lives here and is cleared
   // asynchronously, so a mid-stream reset drops lock without a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= SEED;
         sr_q      <= '0;
         seedCnt_q <= '0;
         winCnt_q  <= '0;
         winErr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         seedCnt_q <= seedCnt_d;
         winCnt_q  <= winCnt_d;
         winErr_q  <= winErr_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic. In SEED the received bits are shifted in until WIDTH
   // of them have arrived; an all-zero register is the LFSR lockup state and
   // would predict zeros forever, so it is thrown away and seeding restarts.
   // In CHECK the local prediction is shifted in rather than the line bit, so
   // one corrupted bit gives exactly one err pulse instead of a burst. The
   // window counters reset on loss of lock and on every window wrap.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      seedCnt_d = seedCnt_q;
      winCnt_d  = winCnt_q;
      winErr_d  = winErr_q;
      err_d     = mismatch;
      if (d_valid) begin
         case (state_q)
            SEED: begin
               sr_d      = srSeed;
               seedCnt_d = seedCnt_q + SEED_W'(1);
               if (seedCnt_d == SEED_W'(WIDTH)) begin
                  seedCnt_d = '0;
                  if (srSeed != '0) begin
                     state_d  = CHECK;
                     winCnt_d = '0;
                     winErr_d = '0;
                  end
               end
            end
            CHECK: begin
               sr_d     = {sr_q[WIDTH-2:0], predBit};
               winCnt_d = winCnt_q + WIN_W'(1);
               winErr_d = winErr_q + ERR_W'(mismatch);
               if (winErr_d == ERR_W'(ERR_THRESH)) begin
                  state_d   = SEED;
                  sr_d      = '0;
                  seedCnt_d = '0;
                  winCnt_d  = '0;
                  winErr_d  = '0;
               end else if (winCnt_d == WIN_W'(WINDOW)) begin
                  winCnt_d = '0;
                  winErr_d = '0;
               end
            end
            default: begin
               state_d = SEED;
            end
         endcase
      end
   end

   // Outputs come straight from registers: lock is the registered state and
   // err is the registered mismatch flag.
   always_comb begin
      locked = (state_q == CHECK);
      err    = err_q;
   end

   // The error counter steps on the same edge that raises err, which makes a
   // clr presented alongside the offending bit win outright.
   prbs_sat_counter #(
      .CNT_W(CNT_W)
   ) u_errCount (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (mismatch),
      .clr_i  (clr),
      .count_o(err_count)
   );

`ifdef PRBS_CHECKER_BITCNT_EN
   // Every valid bit judged in CHECK, including one that costs lock.
   prbs_sat_counter #(
      .CNT_W(CNT_W)
   ) u_bitCount (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (checkBit),
      .clr_i  (clr),
      .count_o(bit_count)
   );
`else
   // Bit counting disabled: no denominator counter is built.
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
// Drives a PRBS7 stream (with chosen bits flipped) into two checkers sharing
// the same inputs: one with the default 16-bit counters and one with 4-bit
// counters to reach saturation. A bit-level model predicts the outputs after
// each edge; predictions are queued on drive and compared on the next edge.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

   localparam int WINDOW     = 64;
   localparam int ERR_THRESH = 4;

   logic       clk;
   logic       reset;
   logic       d;
   logic       dValid;
   logic       clr;
   logic       locked, lockedSat;
   logic       err, errSat;
   logic [15:0] errCount;
   logic [3:0]  errCountSat;
`ifdef PRBS_CHECKER_BITCNT_EN
   logic [15:0] bitCount;
   logic [3:0]  bitCountSat;
`endif

   prbs_checker dut (
      .clk      (clk),
      .reset    (reset),
      .d        (d),
      .d_valid  (dValid),
      .clr      (clr),
      .locked   (locked),
      .err      (err),
`ifdef PRBS_CHECKER_BITCNT_EN
      .bit_count(bitCount),
`endif
      .err_count(errCount)
   );

   prbs_checker #(
      .CNT_W(4)
   ) dutSat (
      .clk      (clk),
      .reset    (reset),
      .d        (d),
      .d_valid  (dValid),
      .clr      (clr),
      .locked   (lockedSat),
      .err      (errSat),
`ifdef PRBS_CHECKER_BITCNT_EN
      .bit_count(bitCountSat),
`endif
      .err_count(errCountSat)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic        locked;
      logic [15:0] cnt;
      logic [3:0]  cntSat;
      logic [15:0] bits;
      logic [3:0]  bitsSat;
   } expect_t;

   expect_t sbQueue[$];
   int      flips[$];
   int      clrAt;
   int      checkCount;
   int      passCount;
   string   phase;
   logic [6:0] gen;

   logic mState;
   logic [6:0] mSr;
   int   mSeedCnt, mWinCnt, mWinErr, mCnt, mCntSat, mBits, mBitsSat;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s.%s observed=%0h expected=%0h", phase, tag, observed, expected);
      end
   endtask

   // Next bit of the x^7+x^6+1 generator; the emitted bit is the feedback.
   task automatic genBit(output logic b);
      b   = gen[6] ^ gen[5];
      gen = {gen[5:0], b};
   endtask

   function automatic bit isFlip(input int idx);
      foreach (flips[k]) begin
         if (flips[k] == idx) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic modelReset();
      mState   = 1'b0;
      mSr      = '0;
      mSeedCnt = 0;
      mWinCnt  = 0;
      mWinErr  = 0;
      mCnt     = 0;
      mCntSat  = 0;
      mBits    = 0;
      mBitsSat = 0;
      sbQueue.delete();
   endtask

   // Bit-level reference: learn seven bits, then predict s[n] = s[n-7]^s[n-6].
   task automatic modelStep(input logic dIn, input logic vIn, input logic cIn);
      logic    p;
      logic    mis;
      logic    wasCheck;
      expect_t e;
      mis      = 1'b0;
      wasCheck = mState;
      if (vIn) begin
         if (!mState) begin
            mSr = {mSr[5:0], dIn};
            mSeedCnt++;
            if (mSeedCnt == 7) begin
               mSeedCnt = 0;
               if (mSr != 7'd0) begin
                  mState  = 1'b1;
                  mWinCnt = 0;
                  mWinErr = 0;
               end
            end
         end else begin
            p   = mSr[6] ^ mSr[5];
            mis = (dIn != p);
            mSr = {mSr[5:0], p};
            mWinCnt++;
            if (mis) mWinErr++;
            if (mWinErr == ERR_THRESH) begin
               mState   = 1'b0;
               mSeedCnt = 0;
               mSr      = '0;
            end else if (mWinCnt == WINDOW) begin
               mWinCnt = 0;
               mWinErr = 0;
            end
         end
      end
      if (cIn) begin
         mCnt = 0; mCntSat = 0; mBits = 0; mBitsSat = 0;
      end else begin
         if (mis && mCnt < 65535) mCnt++;
         if (mis && mCntSat < 15) mCntSat++;
         if (vIn && wasCheck && mBits < 65535) mBits++;
         if (vIn && wasCheck && mBitsSat < 15) mBitsSat++;
      end
      e.err     = mis;
      e.locked  = mState;
      e.cnt     = 16'(mCnt);
      e.cntSat  = 4'(mCntSat);
      e.bits    = 16'(mBits);
      e.bitsSat = 4'(mBitsSat);
      sbQueue.push_back(e);
   endtask

   // One clock of stimulus: drive, predict, then compare 1 ns after the edge.
   task automatic applyStimulus(input logic dIn, input logic vIn, input logic cIn);
      expect_t e;
      d      = dIn;
      dValid = vIn;
      clr    = cIn;
      modelStep(dIn, vIn, cIn);
      @(posedge clk);
      #1;
      if (sbQueue.size() == 0) begin
         checkOutput("scoreboard", 32'd0, 32'd1);
      end else begin
         e = sbQueue.pop_front();
         checkOutput("err", 32'(err), 32'(e.err));
         checkOutput("locked", 32'(locked), 32'(e.locked));
         checkOutput("errCount", 32'(errCount), 32'(e.cnt));
         checkOutput("errSat", 32'(errSat), 32'(e.err));
         checkOutput("lockedSat", 32'(lockedSat), 32'(e.locked));
         checkOutput("errCountSat", 32'(errCountSat), 32'(e.cntSat));
`ifdef PRBS_CHECKER_BITCNT_EN
         checkOutput("bitCount", 32'(bitCount), 32'(e.bits));
         checkOutput("bitCountSat", 32'(bitCountSat), 32'(e.bitsSat));
`endif
      end
   endtask

   // Generator bits with listed indices flipped; optional idle gap after each.
   task automatic sendStream(input int nBits, input bit withGaps);
      logic b;
      for (int i = 0; i < nBits; i++) begin
         genBit(b);
         if (isFlip(i)) b = ~b;
         applyStimulus(b, 1'b1, (i == clrAt));
         if (withGaps) applyStimulus(1'($urandom_range(1)), 1'b0, 1'b0);
      end
   endtask

   task automatic checkAllZero();
      checkOutput("rstLocked", 32'(locked), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstErrCount", 32'(errCount), 32'd0);
      checkOutput("rstLockedSat", 32'(lockedSat), 32'd0);
      checkOutput("rstErrSat", 32'(errSat), 32'd0);
      checkOutput("rstErrCountSat", 32'(errCountSat), 32'd0);
`ifdef PRBS_CHECKER_BITCNT_EN
      checkOutput("rstBitCount", 32'(bitCount), 32'd0);
`endif
   endtask

   task automatic doReset();
      reset  = 1'b0;
      dValid = 1'b0;
      clr    = 1'b0;
      d      = 1'b0;
      modelReset();
      repeat (2) begin
         @(posedge clk);
         #1;
         checkAllZero();
      end
      reset = 1'b1;
   endtask

   // Hard stop if the stimulus ever stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic b;
      checkCount = 0;
      passCount  = 0;
      clrAt      = -1;

      phase = "reset";
      doReset();

      phase = "clean";
      gen = 7'h7F;
      flips.delete();
      sendStream(200, 1'b0);

      phase = "single";
      doReset();
      gen = 7'h7F;
      flips = '{50};
      sendStream(200, 1'b0);
      checkOutput("finalCount", 32'(errCount), 32'd1);
      checkOutput("finalLocked", 32'(locked), 32'd1);

      phase = "lossOfLock";
      doReset();
      gen = 7'h7F;
      flips = '{20, 25, 30, 35};
      sendStream(100, 1'b0);
      checkOutput("finalCount", 32'(errCount), 32'd4);
      checkOutput("finalLocked", 32'(locked), 32'd1);

      phase = "zeroSeed";
      doReset();
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      gen = 7'h7F;
      flips.delete();
      sendStream(50, 1'b0);

      phase = "gaps";
      doReset();
      gen = 7'h7F;
      sendStream(150, 1'b1);

      phase = "clr";
      flips = '{10, 20};
      clrAt = 20;
      sendStream(40, 1'b0);
      clrAt = -1;
      checkOutput("finalCount", 32'(errCount), 32'd0);

      phase = "saturate";
      doReset();
      gen = 7'h7F;
      flips.delete();
      for (int k = 0; k < 20; k++) flips.push_back(40 + 80 * k);
      sendStream(1620, 1'b0);
      genBit(b);
      applyStimulus(~b, 1'b1, 1'b0);
      checkOutput("finalCountSat", 32'(errCountSat), 32'd15);
      checkOutput("finalCount", 32'(errCount), 32'd21);

      phase = "asyncReset";
      #2;
      reset = 1'b0;
      #1;
      checkAllZero();
      modelReset();
      reset = 1'b1;
      gen = 7'h7F;
      flips.delete();
      sendStream(20, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the LFSR stage used for pseudo-random stimulus and request generation.
- Accepts a serial bit stream produced by an LFSR built from that stage and seeds a local Fibonacci LFSR from the first WIDTH received bits.
- Then predicts every following bit and flags mismatches, lock status and a saturating error count.
- Sits on the serial link between the random-request generator and the elevator controller for built-in self-check.

Parameters:
- WIDTH, 7, LFSR length in bits (legal 3..32).
- TAPS, 7'b1100000, feedback mask; bit i set means sr[i] feeds the XOR (default x^7+x^6+1, PRBS7).
- WINDOW, 64, valid bits per error-evaluation window (power of two, >= 2*WIDTH).
- ERR_THRESH, 4, errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16, width of err_count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low (0 = reset asserted)
- d  input  1  serial data bit under test
- d_valid  input  1  d is sampled on this clock edge when high
- clr  input  1  synchronous clear of err_count; does not affect lock
- locked  output  1  high while in CHECK state
- err  output  1  one-cycle pulse, registered, on each mismatching bit in CHECK
- err_count  output  CNT_W  saturating count of mismatches since reset/clr

Behaviour:
- Reset (reset==0, async): state=SEED, sr=0, seed_cnt=0, win_cnt=0, win_err=0, locked=0, err=0, err_count=0.
- Idle hold: cycles with d_valid==0 change nothing except err, which returns to 0.
- Predicted bit: p = XOR-reduce(sr & TAPS).
- SEED state, each valid bit:
  - sr <= {sr[WIDTH-2:0], d}; seed_cnt++.
  - When seed_cnt reaches WIDTH, test the new sr value.
  - All-zero sr: stay in SEED, seed_cnt=0 (lockup state is rejected).
  - Otherwise: go to CHECK, win_cnt=0, win_err=0.
- CHECK state, each valid bit:
  - err <= (d != p).
  - sr <= {sr[WIDTH-2:0], p}. The local prediction is shifted in, so a single line error costs exactly one err pulse.
  - win_cnt++, and win_err++ on mismatch.
  - If win_err reaches ERR_THRESH (including by the current bit): go to SEED, seed_cnt=0, sr=0; locked falls on the next cycle.
  - Else if win_cnt reaches WINDOW: win_cnt=0, win_err=0 (wrap).
- locked is registered: rises the cycle after the WIDTH-th seed bit is accepted.
- Latency: err pulses the cycle after the offending valid bit is sampled.
- err_count:
  - Increments with each err pulse; holds at 2^CNT_W-1 (no wrap).
  - clr==1 sets it to 0 the next cycle.
  - clr and a mismatch in the same cycle: result is 0 (clr wins).
- Mismatches in SEED are never counted.
- Reset mid-stream: immediate return to the reset values above; reseeding starts from the next valid bit after release.

Optional Feature:
- Macro PRBS_CHECKER_BITCNT_EN.
- Defined:
  - Adds output bit_count [CNT_W-1:0], counting valid bits accepted in CHECK.
  - Saturating, cleared by clr and by reset.
  - Gives a bit-error-rate denominator.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package prbs_pkg:
  - typedef enum logic [0:0] {SEED, CHECK} prbs_state_t.
  - Default PRBS7 constants (WIDTH 7, TAPS 7'b1100000).
  - Function for XOR-reduced tap feedback, shared with the generator side.
- One sub-module, prbs_sat_counter: CNT_W saturating counter with inc and clr (clr priority). Instantiated for err_count, and for bit_count when the macro is defined.

Test Plan:
- Clean stream: reset low 2 cycles, then 200 valid PRBS7 bits from seed 7'h7F.
  - locked rises the cycle after bit 7; err never pulses; err_count=0.
- Single error: flip bit 50 of the clean stream.
  - Exactly one err pulse, one cycle after bit 50; err_count=1; locked stays 1.
- Loss of lock: after lock, flip 4 bits within one 64-bit window.
  - locked falls after the 4th error.
  - Reseeds on the next 7 valid bits; locked again; err_count=4.
- All-zero seed: feed 7 zeros, then a valid PRBS7 stream.
  - locked stays 0 through the zeros.
  - Locks 7 valid bits into the stream.
- Gaps and clr:
  - Clean stream with d_valid toggling 1/0: no err, lock behaviour unchanged.
  - clr asserted in the same cycle as a mismatch: err_count=0.
- Saturation and reset: CNT_W=4, inject 20 errors spaced beyond the window.
  - err_count holds at 15.
  - Async reset mid-stream clears all outputs immediately, without waiting for a clock edge.
